bpred_btb: RTL

- Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Produces pred_takenF and pred_targetF in IF, from the current fetch PC. These feed the IF/ID pipeline register and the next-PC mux.
- Trained by branch/jump resolution from EX via a single-cycle update port.
- Writer side of the prediction path: it generates the predictor info that decode later receives.

---
 rtl/bpred_btb_if.sv | 25 ++
 rtl/bpred_btb.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bpred_btb_if.sv
// rtl/bpred_btb_if.sv - fetch lookup and EX update bundle for bpred_btb
//
// Groups the fetch-side lookup (if_pc -> pred_takenF/pred_targetF) and the
// EX-side resolution update (upd_*) used by the branch target buffer.
//   master : pipeline side, drives if_pc and upd_*, receives the prediction
//   slave  : predictor side, receives if_pc and upd_*, drives the prediction
interface bpred_btb_if;
  logic [31:0] if_pc;
  logic        pred_takenF;
  logic [31:0] pred_targetF;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_takenF, pred_targetF
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_takenF, pred_targetF
  );
endinterface

// File: rtl/bpred_btb.sv
// rtl/bpred_btb.sv - direct-mapped BTB with 2-bit direction counters
//
// Purpose: fetch-stage branch predictor. A flop-based table indexed by
// pc[INDEX_BITS+1:2] holds valid/tag/target/2-bit counter per entry. Lookup
// is combinational from the registered table; training arrives from EX.
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   bus              bpred_btb_if.slave (if_pc, pred_takenF, pred_targetF,
//                    upd_valid, upd_pc, upd_taken, upd_target)
//   stat_updates     accepted update count       (BPRED_STATS_EN only)
//   stat_mispredicts mispredicted update count   (BPRED_STATS_EN only)
// Optional feature macro: BPRED_STATS_EN
module bpred_btb #(
  parameter  int INDEX_BITS = 4,
  localparam int TAG_BITS   = 30 - INDEX_BITS,
  localparam int ENTRIES    = 1 << INDEX_BITS
) (
  input  logic clk,
  input  logic reset,
  bpred_btb_if.slave bus
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
`endif
);

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  lk_hit;
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0]   up_tag;
  logic                  up_hit;
  logic                  up_pred_taken;

  // Byte-offset bits of both PCs never address the table.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

  // Lookup path: reads only registered state, so an update in the same
  // cycle to the same entry is not visible until the following cycle.
  assign lk_idx = bus.if_pc[INDEX_BITS+1:2];
  assign lk_tag = bus.if_pc[31:INDEX_BITS+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign bus.pred_takenF  = lk_hit && ctr_q[lk_idx][1];
  assign bus.pred_targetF = bus.pred_takenF ? target_q[lk_idx] : bus.if_pc + 32'd4;

  assign up_idx        = bus.upd_pc[INDEX_BITS+1:2];
  assign up_tag        = bus.upd_pc[31:INDEX_BITS+2];
  assign up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_pred_taken = up_hit && ctr_q[up_idx][1];

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bus.upd_valid) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
          target_d[up_idx] = bus.upd_target;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        // Allocation evicts whatever aliased entry lived here; new entries
        // start weakly taken. Not-taken misses never allocate.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = bus.upd_target;
        ctr_d[up_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] stat_updates_q, stat_updates_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;
  logic        up_mispredict;

  // Judged against the table as it stood before this update is applied.
  assign up_mispredict = (up_pred_taken != bus.upd_taken) ||
                         (up_pred_taken && bus.upd_taken &&
                          (target_q[up_idx] != bus.upd_target));

  always_comb begin
    stat_updates_d     = stat_updates_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (bus.upd_valid) begin
      stat_updates_d = stat_updates_q + 32'd1;
      if (up_mispredict) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_updates_q     <= stat_updates_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  logic unused_pred_taken;
  assign unused_pred_taken = up_pred_taken;
`endif

endmodule
